// File: rtl/yuv_pkg.sv
// Shared constants and types for the macroblock-to-raster strip converter.
package yuv_pkg;

  localparam int IMG_WIDTH = 1280;
  localparam int MB_COLS   = IMG_WIDTH / 16;
  localparam int Y_WORDS   = 64;
  localparam int MB_WORDS  = 96;
  localparam int ADDR_W    = 17;

  // First (leftmost) pixel of a word sits in bits [31:24].
  localparam bit BYTE_MSB_FIRST = 1'b1;

  typedef enum logic {ROW_YUYV = 1'b0, ROW_Y = 1'b1} row_kind_e;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_e;

  typedef struct packed {
    logic       eos;
    logic       eol;
    logic [7:0] data;
  } out_beat_t;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [1:0] idx;
    idx = BYTE_MSB_FIRST ? 2'd3 - lane : lane;
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/strip_bank_ram.sv
// Simple dual-port strip storage: one write port, one registered read port.
module strip_bank_ram
  import yuv_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic        unused_addr;

  // Addresses are formed at full width; only the bits that reach the array matter.
  assign unused_addr = ^{waddr[ADDR_W-1:AW], raddr[ADDR_W-1:AW]};

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[AW-1:0]];
  end

endmodule

// File: rtl/mb_raster_out.sv
// Collects 4:2:0 macroblocks into a double-buffered 16-row strip and replays it as
// an 8-bit raster: even rows Y/UV interleaved, odd rows luma only.
module mb_raster_out #(
  parameter int IMG_WIDTH = yuv_pkg::IMG_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eol,
  output logic        out_eos
);
  import yuv_pkg::*;

  localparam int MB_COLS = IMG_WIDTH / 16;
  localparam int KW      = $clog2(IMG_WIDTH);
  localparam int MBW     = (MB_COLS > 1) ? $clog2(MB_COLS) : 1;

  localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(IMG_WIDTH / 4);
  localparam logic [ADDR_W-1:0] Y_BANK    = ADDR_W'(16 * IMG_WIDTH / 4);
  localparam logic [ADDR_W-1:0] C_BANK    = ADDR_W'(8 * IMG_WIDTH / 4);

  logic [6:0]        w_cnt;
  logic [MBW-1:0]    mb_cnt;
  logic              wr_bank, rd_bank;
  logic [1:0]        bank_full, full_set, full_clr;
  logic              in_xfer, is_chroma, strip_done;
  logic [ADDR_W-1:0] col_words, y_waddr, c_waddr;

  rd_state_e         rd_state;
  row_kind_e         row_kind;
  logic [3:0]        r_cnt;
  logic [KW-1:0]     k_cnt;
  logic              ph, issue_done, issue, credit, last_k, byte_eol, byte_eos;
  logic [ADDR_W-1:0] y_raddr, c_raddr;
  logic [31:0]       y_rdata, c_rdata;

  logic              vld_p0, uv_p0, eol_p0, eos_p0;
  logic [1:0]        lane_p0;

  out_beat_t         skid_mem [2];
  out_beat_t         head;
  logic              skid_wp, skid_rp, pop, eos_xfer;
  logic [1:0]        skid_cnt;

  // Write side: MB word index -> strip position
  assign in_ready   = !bank_full[wr_bank];
  assign in_xfer    = in_valid && in_ready;
  assign is_chroma  = (w_cnt >= 7'(Y_WORDS));
  assign strip_done = in_xfer && (w_cnt == 7'(MB_WORDS - 1)) && (mb_cnt == MBW'(MB_COLS - 1));
  assign col_words  = ADDR_W'({mb_cnt, w_cnt[1:0]});
  // Chroma words start at 64, so w[4:2] is already (w-64)/4.
  assign y_waddr    = (wr_bank ? Y_BANK : '0) + ADDR_W'(w_cnt[5:2]) * ROW_WORDS + col_words;
  assign c_waddr    = (wr_bank ? C_BANK : '0) + ADDR_W'(w_cnt[4:2]) * ROW_WORDS + col_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt   <= '0;
      mb_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_xfer) begin
      if (w_cnt == 7'(MB_WORDS - 1)) begin
        w_cnt <= '0;
        if (mb_cnt == MBW'(MB_COLS - 1)) begin
          mb_cnt  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          mb_cnt <= mb_cnt + 1'b1;
        end
      end else begin
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

  // Set and clear always target different banks, so both can land in one cycle.
  assign full_set = strip_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = eos_xfer   ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_full <= 2'b00;
    else        bank_full <= (bank_full & ~full_clr) | full_set;
  end

  strip_bank_ram #(.DEPTH(2 * 16 * IMG_WIDTH / 4)) u_luma_ram (
    .clk(clk), .we(in_xfer && !is_chroma), .waddr(y_waddr), .wdata(in_data),
    .re(issue), .raddr(y_raddr), .rdata(y_rdata)
  );

  strip_bank_ram #(.DEPTH(2 * 8 * IMG_WIDTH / 4)) u_chroma_ram (
    .clk(clk), .we(in_xfer && is_chroma), .waddr(c_waddr), .wdata(in_data),
    .re(issue), .raddr(c_raddr), .rdata(c_rdata)
  );

  // Read side: byte issue, one RAM read per emitted byte
  assign row_kind = r_cnt[0] ? ROW_Y : ROW_YUYV;
  assign last_k   = (k_cnt == KW'(IMG_WIDTH - 1));
  assign byte_eol = last_k && (row_kind == ROW_Y || ph);
  assign byte_eos = byte_eol && (r_cnt == 4'd15);
  assign y_raddr  = (rd_bank ? Y_BANK : '0) + ADDR_W'(r_cnt) * ROW_WORDS + ADDR_W'(k_cnt[KW-1:2]);
  assign c_raddr  = (rd_bank ? C_BANK : '0) + ADDR_W'(r_cnt[3:1]) * ROW_WORDS + ADDR_W'(k_cnt[KW-1:2]);

  // Issue only if the skid buffer is guaranteed a free slot when this byte arrives.
  assign credit = (3'(skid_cnt) + 3'(vld_p0)) < (3'd2 + 3'(pop));
  assign issue  = credit && (rd_state == RD_FETCH || (rd_state == RD_STREAM && !issue_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      r_cnt      <= '0;
      k_cnt      <= '0;
      ph         <= 1'b0;
      issue_done <= 1'b0;
    end else if (eos_xfer) begin
      rd_state   <= RD_IDLE;
      rd_bank    <= !rd_bank;
      r_cnt      <= '0;
      k_cnt      <= '0;
      ph         <= 1'b0;
      issue_done <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE:  if (bank_full[rd_bank]) rd_state <= RD_FETCH;
        RD_FETCH: if (issue) rd_state <= RD_STREAM;
        default:  ;
      endcase
      if (issue) begin
        if (row_kind == ROW_YUYV && !ph) begin
          ph <= 1'b1;
        end else begin
          ph <= 1'b0;
          if (last_k) begin
            k_cnt <= '0;
            if (r_cnt == 4'd15) issue_done <= 1'b1;
            else                r_cnt      <= r_cnt + 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Stage p0: RAM word available, byte lane and flags registered alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= issue;
  end

  always_ff @(posedge clk) begin
    lane_p0 <= k_cnt[1:0];
    uv_p0   <= ph;
    eol_p0  <= byte_eol;
    eos_p0  <= byte_eos;
  end

  // Output skid buffer: two entries absorb the in-flight byte under backpressure
  assign pop      = out_valid && out_ready;
  assign eos_xfer = pop && out_eos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_wp  <= 1'b0;
      skid_rp  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (vld_p0) skid_wp <= !skid_wp;
      if (pop)    skid_rp <= !skid_rp;
      skid_cnt <= skid_cnt + {1'b0, vld_p0} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) skid_mem[skid_wp] <= '{eos: eos_p0, eol: eol_p0,
                                       data: word_byte(uv_p0 ? c_rdata : y_rdata, lane_p0)};
  end

  assign out_valid = (skid_cnt != 2'd0);
  assign head      = out_valid ? skid_mem[skid_rp] : '0;
  assign out_data  = head.data;
  assign out_eol   = head.eol;
  assign out_eos   = head.eos;

endmodule

// File: tb/tb_mb_raster_out.sv
// Randomized bench for mb_raster_out (32-pixel strips) against an image-level raster model.
module tb_mb_raster_out;

  localparam int W   = 32;
  localparam int MBC = W / 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_eol;
  logic        out_eos;

  mb_raster_out #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eos(out_eos)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 2;  // 0 always, 1 toggle, 2 held low, 3 manual, 4 hold at eos
  logic [7:0]  img_y  [16][W];
  logic [7:0]  img_uv [8][W];
  logic [31:0] wq [$];
  logic [9:0]  exp_q [$];       // {eos, eol, byte}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fill_image(input bit rnd);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < W; c++) img_y[r][c] = rnd ? 8'($urandom) : 8'(r * 16 + c);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < W; c++) img_uv[r][c] = rnd ? 8'($urandom) : 8'(8'h80 + c);
  endtask

  // Words in MB order from the image; expected raster bytes from the same image.
  task automatic build_strip();
    for (int mb = 0; mb < MBC; mb++)
      for (int w = 0; w < 96; w++) begin
        int row, col;
        logic [31:0] word;
        if (w < 64) begin
          row = w / 4; col = mb * 16 + (w % 4) * 4;
          word = {img_y[row][col], img_y[row][col+1], img_y[row][col+2], img_y[row][col+3]};
        end else begin
          row = (w - 64) / 4; col = mb * 16 + ((w - 64) % 4) * 4;
          word = {img_uv[row][col], img_uv[row][col+1], img_uv[row][col+2], img_uv[row][col+3]};
        end
        wq.push_back(word);
      end
    for (int r = 0; r < 16; r++) begin
      int n;
      n = (r % 2 == 0) ? 2 * W : W;
      for (int j = 0; j < n; j++) begin
        logic [7:0] b;
        if (r % 2 == 1)      b = img_y[r][j];
        else if (j % 2 == 0) b = img_y[r][j/2];
        else                 b = img_uv[r/2][j/2];
        exp_q.push_back({(r == 15 && j == n - 1), (j == n - 1), b});
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int t;
    t = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom();
  endtask

  task automatic send_words(input int n, input int gap);
    for (int i = 0; i < n && wq.size() > 0; i++) begin
      push_word(wq.pop_front());
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("idle_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_eol", out_eol, 1'b0);
    check("rst_out_eos", out_eos, 1'b0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      2:       out_ready = 1'b0;
      4:       out_ready = !(out_valid && out_eos);
      default: ;
    endcase
  end

  // Compare process: every accepted byte against the model, held bytes for stability.
  initial begin
    logic       prev_stall;
    logic [9:0] prev_beat;
    logic [9:0] e;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", {out_valid, out_eos, out_eol, out_data}, {1'b1, prev_beat});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {out_eos, out_eol, out_data}, 10'h3FF ^ {out_eos, out_eol, out_data});
          end else begin
            e = exp_q.pop_front();
            check("out_beat", {out_eos, out_eol, out_data}, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_beat = {out_eos, out_eol, out_data};
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single strip of the reference pattern
    fill_image(1'b0);
    build_strip();
    check("model_size", exp_q.size(), 768);
    check("model_b0", exp_q[0], 10'h000);
    check("model_b1", exp_q[1], 10'h080);
    check("model_b2", exp_q[2], 10'h001);
    check("model_b63", exp_q[63], 10'h19F);
    check("model_b64", exp_q[64], 10'h010);
    check("model_b767", exp_q[767], 10'h30F);
    ready_mode = 0;
    send_words(192, 0);
    wait_drain();

    // Backpressure: out_ready toggling every cycle
    fill_image(1'b1);
    build_strip();
    ready_mode = 1;
    send_words(192, 0);
    wait_drain();

    // Input gaps: one word every three cycles
    ready_mode = 0;
    fill_image(1'b0);
    build_strip();
    send_words(192, 2);
    wait_drain();

    // Both banks full with the sink stalled
    ready_mode = 2;
    for (int s = 0; s < 3; s++) begin
      fill_image(1'b1);
      build_strip();
    end
    send_words(384, 0);
    @(negedge clk);
    check("both_full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    fork
      send_words(192, 0);
      begin
        ready_mode = 0;
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready && out_eos) && t < 3000) begin
          @(negedge clk);
          t++;
        end
        check("eos_cycle_in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("after_eos_in_ready", in_ready, 1'b1);
      end
    join
    wait_drain();

    // Last word of the next strip written on the same edge as the eos transfer
    ready_mode = 4;
    fill_image(1'b1);
    build_strip();
    fill_image(1'b0);
    build_strip();
    send_words(383, 0);
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_eos) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ready_mode = 3;
    check("simul_eos_held", {out_valid, out_eos, out_ready}, 3'b110);
    check("simul_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_data = wq.pop_front();
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ready_mode = 0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("next_strip_latency_ok", (t <= 3), 1'b1);
    wait_drain();

    // Reset in the middle of a strip
    fill_image(1'b1);
    build_strip();
    send_words(100, 0);
    rst_n = 1'b0;
    wq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_image(1'b1);
    build_strip();
    send_words(192, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
